// File: rtl/seg_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : seg_scan_ctrl
// Description : Six-digit multiplexed 7-segment scan controller with blanking,
//               leading-zero suppression and frame-aligned double buffering.
// Revision    : 1.0 - initial release
// ============================================================================
module seg_scan_ctrl #(
    parameter logic [15:0] CNT_DIGIT = 16'd49_999,
    parameter logic [7:0]  CNT_BLANK = 8'd99
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic [23:0] data_in,
    input  logic [5:0]  point_in,
    input  logic [5:0]  en_mask_in,
    input  logic        lz_blank_in,
    input  logic        load_req,
    output logic        load_ack,
    output logic        frame_done,
    output logic [5:0]  sel,
    output logic [7:0]  seg
);

    typedef enum logic [1:0] {
        S_OFF   = 2'd0,
        S_BLANK = 2'd1,
        S_SHOW  = 2'd2
    } state_t;

    localparam logic [2:0]  C_LAST_IDX  = 3'd5;
    localparam logic [15:0] C_BLANK_END = {8'd0, CNT_BLANK};

    state_t      r_state;
    state_t      w_state_nxt;
    logic [2:0]  r_idx;
    logic [2:0]  w_idx_nxt;
    logic [15:0] r_cnt;
    logic [15:0] w_cnt_nxt;
    logic        w_xfer;
    logic        w_frame_end;

    // Staging buffer written by load_req; active buffer drives the display
    logic [23:0] r_stg_data;
    logic [5:0]  r_stg_point;
    logic [5:0]  r_stg_mask;
    logic        r_stg_lz;
    logic        r_pending;
    logic [23:0] r_act_data;
    logic [5:0]  r_act_point;
    logic [5:0]  r_act_mask;
    logic        r_act_lz;

    logic        r_load_ack;
    logic        r_frame_done;
    logic [5:0]  r_sel;
    logic [7:0]  r_seg;
    logic [5:0]  w_sel_nxt;
    logic [7:0]  w_seg_nxt;
    logic [3:0]  w_digit;
    logic [5:0]  w_zero;
    logic [5:0]  w_sup;

    function automatic logic [6:0] hex7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'h0:    s = 7'h40;
            4'h1:    s = 7'h79;
            4'h2:    s = 7'h24;
            4'h3:    s = 7'h30;
            4'h4:    s = 7'h19;
            4'h5:    s = 7'h12;
            4'h6:    s = 7'h02;
            4'h7:    s = 7'h78;
            4'h8:    s = 7'h00;
            4'h9:    s = 7'h10;
            4'hA:    s = 7'h08;
            4'hB:    s = 7'h03;
            4'hC:    s = 7'h46;
            4'hD:    s = 7'h21;
            4'hE:    s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    generate
        for (genvar k = 0; k < 6; k++) begin : g_zero
            assign w_zero[k] = (r_act_data[4*k +: 4] == 4'd0);
        end
    endgenerate

    // A digit is suppressed only while every digit above it is also zero
    always_comb begin
        w_sup    = 6'd0;
        w_sup[5] = r_act_lz & w_zero[5];
        for (int k = 4; k >= 1; k--) begin
            w_sup[k] = w_sup[k+1] & w_zero[k];
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_cnt_nxt   = r_cnt;
        w_xfer      = 1'b0;
        w_frame_end = 1'b0;
        case (r_state)
            S_OFF: begin
                if (r_pending) begin
                    w_xfer      = 1'b1;
                    w_state_nxt = S_BLANK;
                    w_idx_nxt   = 3'd0;
                    w_cnt_nxt   = 16'd0;
                end
            end
            S_BLANK: begin
                if (r_cnt == C_BLANK_END) begin
                    w_state_nxt = S_SHOW;
                    w_cnt_nxt   = 16'd0;
                end else begin
                    w_cnt_nxt = r_cnt + 16'd1;
                end
            end
            S_SHOW: begin
                if (r_cnt == CNT_DIGIT) begin
                    w_state_nxt = S_BLANK;
                    w_cnt_nxt   = 16'd0;
                    if (r_idx == C_LAST_IDX) begin
                        w_idx_nxt   = 3'd0;
                        w_frame_end = 1'b1;
                        w_xfer      = r_pending;
                    end else begin
                        w_idx_nxt = r_idx + 3'd1;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + 16'd1;
                end
            end
            default: begin
                w_state_nxt = S_OFF;
                w_idx_nxt   = 3'd0;
                w_cnt_nxt   = 16'd0;
            end
        endcase
    end

    // Outputs are computed from the next state so they register on the entry edge
    assign w_digit = r_act_data[{w_idx_nxt, 2'b00} +: 4];

    always_comb begin
        w_sel_nxt = 6'd0;
        w_seg_nxt = 8'hFF;
        if ((w_state_nxt == S_SHOW) && r_act_mask[w_idx_nxt]) begin
            w_sel_nxt = 6'b000001 << w_idx_nxt;
            w_seg_nxt = {~r_act_point[w_idx_nxt],
                         w_sup[w_idx_nxt] ? 7'h7F : hex7(w_digit)};
        end
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            r_state      <= S_OFF;
            r_idx        <= 3'd0;
            r_cnt        <= 16'd0;
            r_stg_data   <= 24'd0;
            r_stg_point  <= 6'd0;
            r_stg_mask   <= 6'd0;
            r_stg_lz     <= 1'b0;
            r_pending    <= 1'b0;
            r_act_data   <= 24'd0;
            r_act_point  <= 6'd0;
            r_act_mask   <= 6'd0;
            r_act_lz     <= 1'b0;
            r_load_ack   <= 1'b0;
            r_frame_done <= 1'b0;
            r_sel        <= 6'd0;
            r_seg        <= 8'hFF;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_cnt   <= w_cnt_nxt;
            if (load_req) begin
                r_stg_data  <= data_in;
                r_stg_point <= point_in;
                r_stg_mask  <= en_mask_in;
                r_stg_lz    <= lz_blank_in;
            end
            if (w_xfer) begin
                r_act_data  <= r_stg_data;
                r_act_point <= r_stg_point;
                r_act_mask  <= r_stg_mask;
                r_act_lz    <= r_stg_lz;
            end
            // A request landing on the transfer edge stays pending for the next frame
            r_pending    <= load_req | (r_pending & ~w_xfer);
            r_load_ack   <= w_xfer;
            r_frame_done <= w_frame_end;
            r_sel        <= w_sel_nxt;
            r_seg        <= w_seg_nxt;
        end
    end

    assign load_ack   = r_load_ack;
    assign frame_done = r_frame_done;
    assign sel        = r_sel;
    assign seg        = r_seg;

endmodule
`default_nettype wire

// File: doc/seg_scan_ctrl.md
SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 SHALL provide parameter CNT_DIGIT, default 16'd49_999, giving a digit on-time of CNT_DIGIT+1 cycles (1 ms at 50 MHz).
REQ-002 SHALL provide parameter CNT_BLANK, default 8'd99, giving an inter-digit blanking time of CNT_BLANK+1 cycles.
REQ-003 sys_clk  input  1  single clock; all logic on its rising edge.
REQ-004 sys_rst_n  input  1  reset, synchronous, active-low.
REQ-005 data_in  input  24  six hex digits; digit k = data_in[4k+3:4k]; digit 0 is rightmost.
REQ-006 point_in  input  6  decimal point per digit, 1 = lit.
REQ-007 en_mask_in  input  6  digit enable, 1 = displayed.
REQ-008 lz_blank_in  input  1  1 = suppress leading zeros.
REQ-009 load_req  input  1  request to capture data_in/point_in/en_mask_in/lz_blank_in.
REQ-010 load_ack  output  1  one-cycle pulse when staged data becomes active.
REQ-011 frame_done  output  1  one-cycle pulse at the end of each 6-digit frame.
REQ-012 sel  output  6  digit select, one-hot, active-high.
REQ-013 seg  output  8  segments, active-low; seg[7] = decimal point.

Function
REQ-014 SHALL implement FSM states OFF, BLANK and SHOW, plus a 3-bit digit index idx (range 0..5).
REQ-015 SHALL capture all load inputs into a staging buffer on any cycle with load_req=1 and set a pending flag; a later load_req while pending overwrites staging, last value wins.
REQ-016 OFF: sel=0, seg=8'hFF; if pending, SHALL transfer staging to active, clear pending, pulse load_ack, and go to BLANK with idx=0 on the next edge.
REQ-017 BLANK SHALL last CNT_BLANK+1 cycles with sel=0 and seg=8'hFF, then go to SHOW.
REQ-018 SHOW SHALL last CNT_DIGIT+1 cycles with sel=(1<<idx) and seg=code(idx), then go to BLANK with idx+1.
REQ-019 On SHOW exit with idx=5, idx SHALL wrap to 0 and frame_done SHALL pulse in the first cycle of the next BLANK.
REQ-020 In that same cycle, if pending, SHALL transfer staging to active and pulse load_ack; otherwise the active data is unchanged.
REQ-021 Data transfer SHALL occur only at frame boundaries, so no frame mixes old and new data.
REQ-022 The frame period SHALL be fixed at 6*(CNT_DIGIT+CNT_BLANK+2) cycles regardless of mask or data.
REQ-023 If en_mask[idx]=0, SHOW SHALL keep its full slot timing but drive sel=0 and seg=8'hFF.
REQ-024 Hex encoding of seg[6:0], digits 0-F: 40,79,24,30,19,12,02,78,00,10,08,03,46,21,06,0E.
REQ-025 seg[7] SHALL be the inverse of point[idx].
REQ-026 When lz_blank=1, digits from 5 downward SHALL have seg[6:0]=7'h7F while each is 0, up to the first nonzero digit.
REQ-027 Digit 0 SHALL never be zero-suppressed, and a suppressed digit SHALL still show its point.
REQ-028 sel and seg SHALL be registered and SHALL change on the same edge that enters the state or idx they reflect.
REQ-029 Outputs SHALL be glitch-free, with at most one sel bit high at any time.

Reset
REQ-030 While sys_rst_n=0 at an edge, the block SHALL load: state OFF, idx=0, staging/active/pending cleared, sel=0, seg=8'hFF, load_ack=0, frame_done=0.
REQ-031 Reset mid-frame SHALL discard active and pending data, and after release the display SHALL stay blank until the next load_req.

Verification (CNT_DIGIT=9, CNT_BLANK=1: slot = 12 cycles, frame = 72 cycles)
REQ-032 Reset, no load_req for 500 cycles -> sel=0, seg=FF, no load_ack or frame_done pulses.
REQ-033 load_req 1 cycle with data 24'h123456, point 0, mask 3F, lz 0 -> load_ack next cycle, then per digit 0..5: sel 01/02/04/08/10/20 with seg 82/92/99/B0/A4/F9, each for 10 cycles, separated by 2 blank cycles; frame_done every 72 cycles.
REQ-034 data 24'h0000A0, lz 1, point 6'b000100 -> digits 5,4,3 seg FF; digit 2 seg 7F; digit 1 seg 88; digit 0 seg C0.
REQ-035 While scanning, load_req at cycle 20 and again at cycle 40 of a frame -> the old data is shown for the rest of that frame; a single load_ack coincides with frame_done; the next frame shows the second request's data.
REQ-036 mask 6'b000010 -> sel only ever 02; all other slots sel=0, seg FF; frame period still 72.
REQ-037 sys_rst_n low for 1 cycle during SHOW of digit 3 -> next edge sel=0, seg=FF; no output activity until a new load_req.
